// File: rtl/l1i_tag_controller.sv
// l1i_tag_controller: sequences fetch lookups into the L1 instruction-cache tag
// query stage, classifies each returning query as hit or miss, and on a miss
// flushes in-flight lookups, requests the line from memory and writes the new
// tag into the tag memory when the refill completes.
module l1i_tag_controller #(
    parameter int offsetSize = 5,
    parameter int indexSize  = 8,
    parameter int tagSize    = 64 - (offsetSize + indexSize)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    // fetch unit side
    input  logic                  fetchReq_i,
    input  logic [tagSize-1:0]    fetchTag_i,
    input  logic [indexSize-1:0]  fetchIndex_i,
    input  logic [offsetSize-1:0] fetchOffset_i,
    input  logic                  fetchUnitStall_i,
    input  logic                  flushPipeline_i,
    output logic                  fetchReady_o,
    // tag query stage control
    output logic                  fetchEnable_o,
    output logic [tagSize-1:0]    tag_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o,
    output logic                  updateEnable_o,
    output logic [tagSize-1:0]    newTag_o,
    output logic [indexSize-1:0]  newIndex_o,
    output logic                  tagQueryStall_o,
    output logic                  flushPipeline_o,
    // tag query stage results
    input  logic                  queryEnable_i,
    input  logic [tagSize-1:0]    queryTag_i,
    input  logic [indexSize-1:0]  queryIndex_i,
    input  logic [offsetSize-1:0] queryOffset_i,
    input  logic [tagSize:0]      queriedTag_i,
    // lookup outcome
    output logic                  hit_o,
    output logic                  miss_o,
    output logic [63:0]           missAddr_o,
    // memory side
    output logic                  memReq_o,
    input  logic                  memAck_i,
    input  logic                  memDone_i,
    output logic [15:0]           missCount_o
);

    typedef enum logic [2:0] {
        READY,
        FLUSH,
        REQ,
        WAIT,
        WRITE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [tagSize-1:0]     miss_tag_q;
    logic [indexSize-1:0]   miss_index_q;
    logic [15:0]            miss_count_q;

    logic                   in_ready;
    logic                   tag_match;
    logic                   lookup_valid;
    logic                   miss_detect;

    // The offset of a returning query never matters: refills are line-aligned.
    logic                   unused_query_offset;
    assign unused_query_offset = ^queryOffset_i;

    // State register, captured miss address and saturating miss counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= READY;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            miss_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_detect) begin
                miss_tag_q   <= queryTag_i;
                miss_index_q <= queryIndex_i;
                if (miss_count_q != 16'hFFFF) begin
                    miss_count_q <= miss_count_q + 16'd1;
                end
            end
        end
    end

    // Lookup results only count in READY and when no external flush is killing them.
    always_comb begin
        in_ready     = (state_q == READY);
        tag_match    = queriedTag_i[0] && (queriedTag_i[tagSize:1] == queryTag_i);
        lookup_valid = in_ready && queryEnable_i && !flushPipeline_i;
        miss_detect  = lookup_valid && !tag_match;
    end

    // Next-state logic and all controller outputs.
    always_comb begin
        state_d         = state_q;
        fetchReady_o    = 1'b0;
        fetchEnable_o   = 1'b0;
        tag_o           = '0;
        index_o         = '0;
        offset_o        = '0;
        updateEnable_o  = 1'b0;
        newTag_o        = '0;
        newIndex_o      = '0;
        tagQueryStall_o = !in_ready || fetchUnitStall_i;
        flushPipeline_o = flushPipeline_i && in_ready;
        hit_o           = lookup_valid && tag_match;
        miss_o          = 1'b0;
        missAddr_o      = {miss_tag_q, miss_index_q, {offsetSize{1'b0}}};
        memReq_o        = 1'b0;
        missCount_o     = miss_count_q;

        fetchReady_o  = in_ready && !fetchUnitStall_i && !reset_i;
        fetchEnable_o = fetchReq_i && fetchReady_o;
        if (fetchEnable_o) begin
            tag_o    = fetchTag_i;
            index_o  = fetchIndex_i;
            offset_o = fetchOffset_i;
        end

        case (state_q)
            READY: begin
                if (miss_detect) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flushPipeline_o = 1'b1;
                miss_o          = 1'b1;
                state_d         = REQ;
            end
            REQ: begin
                memReq_o = 1'b1;
                if (memAck_i) begin
                    state_d = memDone_i ? WRITE : WAIT;
                end
            end
            WAIT: begin
                if (memDone_i) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                updateEnable_o = 1'b1;
                newTag_o       = miss_tag_q;
                newIndex_o     = miss_index_q;
                state_d        = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

endmodule

// File: tb/tb_l1i_tag_controller.sv
// tb_l1i_tag_controller: directed bench with a behavioural two-stage tag query
// stage and tag memory around the controller, and a scoreboard of expected
// hit/miss outcomes pushed at lookup time and popped when the controller reports.
module tb_l1i_tag_controller;

    localparam int OFF = 5;
    localparam int IDX = 8;
    localparam int TAG = 64 - (OFF + IDX);

    typedef struct {
        bit          isHit;
        logic [63:0] addr;
    } expect_t;

    logic           clock = 1'b0;
    logic           reset_i = 1'b1;
    logic           fetchReq_i = 1'b0;
    logic [TAG-1:0] fetchTag_i = '0;
    logic [IDX-1:0] fetchIndex_i = '0;
    logic [OFF-1:0] fetchOffset_i = '0;
    logic           fetchUnitStall_i = 1'b0;
    logic           flushPipeline_i = 1'b0;
    logic           fetchReady_o;
    logic           fetchEnable_o;
    logic [TAG-1:0] tag_o;
    logic [IDX-1:0] index_o;
    logic [OFF-1:0] offset_o;
    logic           updateEnable_o;
    logic [TAG-1:0] newTag_o;
    logic [IDX-1:0] newIndex_o;
    logic           tagQueryStall_o;
    logic           flushPipeline_o;
    logic           queryEnable_i;
    logic [TAG-1:0] queryTag_i;
    logic [IDX-1:0] queryIndex_i;
    logic [OFF-1:0] queryOffset_i;
    logic [TAG:0]   queriedTag_i;
    logic           hit_o;
    logic           miss_o;
    logic [63:0]    missAddr_o;
    logic           memReq_o;
    logic           memAck_i = 1'b0;
    logic           memDone_i = 1'b0;
    logic [15:0]    missCount_o;

    // Behavioural tag query stage state
    logic           p1Valid = 1'b0;
    logic [TAG-1:0] p1Tag = '0;
    logic [IDX-1:0] p1Index = '0;
    logic [OFF-1:0] p1Offset = '0;
    logic           p2Valid = 1'b0;
    logic [TAG-1:0] p2Tag = '0;
    logic [IDX-1:0] p2Index = '0;
    logic [OFF-1:0] p2Offset = '0;
    logic [TAG:0]   tagMem [256] = '{default: '0};
    logic           preloadEn = 1'b0;
    logic [IDX-1:0] preloadIndex = '0;
    logic [TAG-1:0] preloadTag = '0;

    // Reference tag contents used to predict hit or miss
    logic [TAG-1:0] refTag [256] = '{default: '0};
    bit             refValid [256] = '{default: 1'b0};

    expect_t        expQ [$];
    int             compareCount = 0;
    int             failCount = 0;

    l1i_tag_controller #(
        .offsetSize(OFF),
        .indexSize (IDX),
        .tagSize   (TAG)
    ) dut (
        .clock_i         (clock),
        .reset_i         (reset_i),
        .fetchReq_i      (fetchReq_i),
        .fetchTag_i      (fetchTag_i),
        .fetchIndex_i    (fetchIndex_i),
        .fetchOffset_i   (fetchOffset_i),
        .fetchUnitStall_i(fetchUnitStall_i),
        .flushPipeline_i (flushPipeline_i),
        .fetchReady_o    (fetchReady_o),
        .fetchEnable_o   (fetchEnable_o),
        .tag_o           (tag_o),
        .index_o         (index_o),
        .offset_o        (offset_o),
        .updateEnable_o  (updateEnable_o),
        .newTag_o        (newTag_o),
        .newIndex_o      (newIndex_o),
        .tagQueryStall_o (tagQueryStall_o),
        .flushPipeline_o (flushPipeline_o),
        .queryEnable_i   (queryEnable_i),
        .queryTag_i      (queryTag_i),
        .queryIndex_i    (queryIndex_i),
        .queryOffset_i   (queryOffset_i),
        .queriedTag_i    (queriedTag_i),
        .hit_o           (hit_o),
        .miss_o          (miss_o),
        .missAddr_o      (missAddr_o),
        .memReq_o        (memReq_o),
        .memAck_i        (memAck_i),
        .memDone_i       (memDone_i),
        .missCount_o     (missCount_o)
    );

    always #5 clock = ~clock;

    assign queryEnable_i = p2Valid;
    assign queryTag_i    = p2Tag;
    assign queryIndex_i  = p2Index;
    assign queryOffset_i = p2Offset;
    assign queriedTag_i  = tagMem[p2Index];

    // Two-cycle tag query pipeline plus tag memory, driven by the controller outputs.
    always @(posedge clock) begin
        if (reset_i || flushPipeline_o) begin
            p1Valid <= 1'b0;
            p2Valid <= 1'b0;
        end else if (!tagQueryStall_o) begin
            p1Valid  <= fetchEnable_o;
            p1Tag    <= tag_o;
            p1Index  <= index_o;
            p1Offset <= offset_o;
            p2Valid  <= p1Valid;
            p2Tag    <= p1Tag;
            p2Index  <= p1Index;
            p2Offset <= p1Offset;
        end
        if (updateEnable_o) begin
            tagMem[newIndex_o] <= {newTag_o, 1'b1};
        end
        if (preloadEn) begin
            tagMem[preloadIndex] <= {preloadTag, 1'b1};
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
        fetchReq_i      = 1'b0;
        fetchTag_i      = '0;
        fetchIndex_i    = '0;
        fetchOffset_i   = '0;
        flushPipeline_i = 1'b0;
        memAck_i        = 1'b0;
        memDone_i       = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic [TAG-1:0] tag, input logic [IDX-1:0] idx,
                                 input logic [OFF-1:0] off, input bit killed);
        expect_t e;
        fetchReq_i    = 1'b1;
        fetchTag_i    = tag;
        fetchIndex_i  = idx;
        fetchOffset_i = off;
        if (!killed) begin
            e.isHit = refValid[idx] && (refTag[idx] == tag);
            e.addr  = {tag, idx, 5'b0};
            expQ.push_back(e);
        end
    endtask

    task automatic lookupAndDrain(input logic [TAG-1:0] tag, input logic [IDX-1:0] idx);
        nextCycle();
        applyStimulus(tag, idx, 5'h0, 1'b0);
        repeat (3) nextCycle();
    endtask

    // Scoreboard: every reported hit or miss must match the oldest expected outcome.
    always @(negedge clock) begin
        if (!reset_i && (hit_o === 1'b1 || miss_o === 1'b1)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResult", {62'b0, hit_o, miss_o}, 64'h0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("resultKind", {62'b0, hit_o, miss_o}, e.isHit ? 64'h2 : 64'h1);
                if (miss_o === 1'b1) begin
                    checkOutput("scoreMissAddr", missAddr_o, e.addr);
                end
            end
        end
    end

    initial begin
        // Reset behaviour
        nextCycle();
        nextCycle();
        fetchReq_i = 1'b1;
        settle();
        checkOutput("resetFetchReady", fetchReady_o, 0);
        checkOutput("resetFetchEnable", fetchEnable_o, 0);
        fetchReq_i = 1'b0;
        reset_i    = 1'b0;
        nextCycle();
        settle();
        checkOutput("resetMissCount", missCount_o, 0);
        checkOutput("resetMemReq", memReq_o, 0);
        checkOutput("resetUpdateEnable", updateEnable_o, 0);
        checkOutput("resetFlushOut", flushPipeline_o, 0);
        checkOutput("resetStall", tagQueryStall_o, 0);
        checkOutput("readyAfterReset", fetchReady_o, 1);

        // Hit on a preloaded line
        $display("[TB] hit on preloaded line");
        preloadEn    = 1'b1;
        preloadIndex = 8'h05;
        preloadTag   = 51'h1234;
        refTag[8'h05]   = 51'h1234;
        refValid[8'h05] = 1'b1;
        nextCycle();
        preloadEn = 1'b0;
        applyStimulus(51'h1234, 8'h05, 5'h3, 1'b0);
        settle();
        checkOutput("hitFetchEnable", fetchEnable_o, 1);
        checkOutput("hitTagOut", tag_o, 51'h1234);
        checkOutput("hitIndexOut", index_o, 8'h05);
        checkOutput("hitOffsetOut", offset_o, 5'h3);
        nextCycle();
        settle();
        checkOutput("idleTagZero", tag_o, 0);
        checkOutput("idleIndexZero", index_o, 0);
        checkOutput("idleOffsetZero", offset_o, 0);
        nextCycle();
        settle();
        checkOutput("hitPulse", hit_o, 1);
        checkOutput("hitNoFlush", flushPipeline_o, 0);
        nextCycle();
        settle();
        checkOutput("hitPulseEnds", hit_o, 0);
        checkOutput("hitNoMemReq", memReq_o, 0);
        checkOutput("hitNoMissCount", missCount_o, 0);

        // Cold miss with separate ack and done
        $display("[TB] cold miss");
        nextCycle();
        applyStimulus(51'h7, 8'h10, 5'h1f, 1'b0);
        nextCycle();
        nextCycle();
        settle();
        checkOutput("coldMissNotYet", miss_o, 0);
        nextCycle();
        settle();
        checkOutput("coldMissPulse", miss_o, 1);
        checkOutput("coldFlushOut", flushPipeline_o, 1);
        checkOutput("coldMissAddr", missAddr_o, {51'h7, 8'h10, 5'h0});
        checkOutput("coldNoReqInFlush", memReq_o, 0);
        checkOutput("coldMissCount", missCount_o, 1);
        nextCycle();
        settle();
        checkOutput("coldMemReqRise", memReq_o, 1);
        nextCycle();
        nextCycle();
        memAck_i = 1'b1;
        settle();
        checkOutput("coldMemReqHeld", memReq_o, 1);
        nextCycle();
        settle();
        checkOutput("coldWaitNoReq", memReq_o, 0);
        nextCycle();
        fetchReq_i = 1'b1;
        settle();
        checkOutput("coldWaitNotReady", fetchReady_o, 0);
        checkOutput("coldWaitNoFetch", fetchEnable_o, 0);
        nextCycle();
        memDone_i = 1'b1;
        settle();
        checkOutput("coldNoEarlyUpdate", updateEnable_o, 0);
        nextCycle();
        fetchReq_i = 1'b1;
        settle();
        checkOutput("coldUpdate", updateEnable_o, 1);
        checkOutput("coldNewTag", newTag_o, 51'h7);
        checkOutput("coldNewIndex", newIndex_o, 8'h10);
        checkOutput("coldWriteNoFetch", fetchEnable_o, 0);
        refTag[8'h10]   = 51'h7;
        refValid[8'h10] = 1'b1;
        nextCycle();
        settle();
        checkOutput("coldUpdateOnce", updateEnable_o, 0);
        checkOutput("coldNewTagZero", newTag_o, 0);
        checkOutput("coldReadyAgain", fetchReady_o, 1);
        lookupAndDrain(51'h7, 8'h10);

        // Back-to-back lookups, first misses; ack and done coincide
        $display("[TB] back-to-back lookups after a miss");
        nextCycle();
        applyStimulus(51'h9, 8'h20, 5'h0, 1'b0);
        nextCycle();
        applyStimulus(51'h1234, 8'h05, 5'h0, 1'b1);
        nextCycle();
        applyStimulus(51'h7, 8'h10, 5'h0, 1'b1);
        settle();
        checkOutput("b2bThirdAccepted", fetchEnable_o, 1);
        nextCycle();
        settle();
        checkOutput("b2bMissPulse", miss_o, 1);
        checkOutput("b2bNoHit", hit_o, 0);
        checkOutput("b2bMissAddr", missAddr_o, {51'h9, 8'h20, 5'h0});
        checkOutput("b2bMissCount", missCount_o, 2);
        nextCycle();
        memAck_i  = 1'b1;
        memDone_i = 1'b1;
        settle();
        checkOutput("b2bMemReq", memReq_o, 1);
        checkOutput("b2bNoHitLater", hit_o, 0);
        nextCycle();
        settle();
        checkOutput("skipWaitUpdate", updateEnable_o, 1);
        checkOutput("skipWaitNoReq", memReq_o, 0);
        checkOutput("skipWaitNewTag", newTag_o, 51'h9);
        checkOutput("skipWaitNewIndex", newIndex_o, 8'h20);
        refTag[8'h20]   = 51'h9;
        refValid[8'h20] = 1'b1;
        nextCycle();
        settle();
        checkOutput("b2bReady", fetchReady_o, 1);
        checkOutput("b2bMissCountStable", missCount_o, 2);

        // External flush during WAIT is ignored
        $display("[TB] flush during refill");
        nextCycle();
        applyStimulus(51'hA, 8'h30, 5'h0, 1'b0);
        repeat (3) nextCycle();
        nextCycle();
        memAck_i = 1'b1;
        nextCycle();
        flushPipeline_i = 1'b1;
        settle();
        checkOutput("waitFlushIgnored", flushPipeline_o, 0);
        checkOutput("waitFlushNoReq", memReq_o, 0);
        nextCycle();
        flushPipeline_i = 1'b1;
        memDone_i       = 1'b1;
        nextCycle();
        settle();
        checkOutput("waitFlushUpdate", updateEnable_o, 1);
        checkOutput("waitFlushNewTag", newTag_o, 51'hA);
        checkOutput("waitFlushNewIndex", newIndex_o, 8'h30);
        refTag[8'h30]   = 51'hA;
        refValid[8'h30] = 1'b1;
        nextCycle();
        settle();
        checkOutput("waitFlushMissCount", missCount_o, 3);

        // External flush in READY suppresses miss handling
        $display("[TB] flush alongside missing result");
        nextCycle();
        applyStimulus(51'hB, 8'h40, 5'h0, 1'b1);
        nextCycle();
        nextCycle();
        flushPipeline_i = 1'b1;
        settle();
        checkOutput("readyFlushOut", flushPipeline_o, 1);
        checkOutput("readyFlushNoHit", hit_o, 0);
        nextCycle();
        settle();
        checkOutput("readyFlushNoMiss", miss_o, 0);
        checkOutput("readyFlushNoStall", tagQueryStall_o, 0);
        checkOutput("readyFlushStillReady", fetchReady_o, 1);
        nextCycle();
        settle();
        checkOutput("readyFlushNoMemReq", memReq_o, 0);
        checkOutput("readyFlushMissCount", missCount_o, 3);

        // Reset during WAIT abandons the refill
        $display("[TB] reset mid-refill");
        nextCycle();
        applyStimulus(51'hC, 8'h50, 5'h0, 1'b0);
        repeat (3) nextCycle();
        nextCycle();
        memAck_i = 1'b1;
        nextCycle();
        reset_i = 1'b1;
        nextCycle();
        reset_i   = 1'b0;
        memDone_i = 1'b1;
        settle();
        checkOutput("resetWaitMemReq", memReq_o, 0);
        checkOutput("resetWaitMissCount", missCount_o, 0);
        checkOutput("resetWaitReady", fetchReady_o, 1);
        checkOutput("resetWaitUpdate", updateEnable_o, 0);
        nextCycle();
        settle();
        checkOutput("resetWaitNoWrite", updateEnable_o, 0);
        checkOutput("resetWaitNoReqAfter", memReq_o, 0);
        nextCycle();
        settle();
        checkOutput("resetWaitNoWriteLate", updateEnable_o, 0);

        // Refilled lines now hit
        lookupAndDrain(51'hA, 8'h30);
        lookupAndDrain(51'h9, 8'h20);
        nextCycle();
        settle();
        checkOutput("finalMissCount", missCount_o, 0);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
